// File: rtl/aes_word_sequencer_if.sv
// aes_word_sequencer_if: block-side handshakes and core word port of the AES word sequencer
interface aes_word_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic [127:0] in_key;
  logic [127:0] in_text;
  logic ld;
  logic [31:0] key;
  logic [31:0] text_in;
  logic done;
  logic [31:0] text_out;
  logic out_valid;
  logic out_ready;
  logic [127:0] out_data;
  logic busy;
  logic timeout_err;
  modport slave(
    input in_valid, in_key, in_text, done, text_out, out_ready,
    output in_ready, ld, key, text_in, out_valid, out_data, busy, timeout_err
  );
  modport master(
    output in_valid, in_key, in_text, done, text_out, out_ready,
    input in_ready, ld, key, text_in, out_valid, out_data, busy, timeout_err
  );
endinterface

// File: rtl/aes_word_sequencer.sv
// aes_word_sequencer: serializes a 128-bit key/text block into four core beats and gathers the 128-bit result
module aes_word_sequencer #(
  parameter int DONE_TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  aes_word_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, COLLECT, HOLD} state_t;
  localparam logic [7:0] TMAX = 8'(DONE_TIMEOUT);
  state_t state;
  logic [1:0] beat;
  logic [1:0] nb;
  logic [7:0] tcnt;
  logic [127:0] key_reg;
  logic [127:0] text_reg;
  logic [95:0] res;
  assign nb = beat + 2'd1;
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  // word n of a block sits at bits 127-32n; ~nb*32 is that word's base for the next beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      tcnt <= '0;
      key_reg <= '0;
      text_reg <= '0;
      res <= '0;
      bus.ld <= 1'b0;
      bus.key <= '0;
      bus.text_in <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          key_reg <= bus.in_key;
          text_reg <= bus.in_text;
          beat <= '0;
          bus.ld <= 1'b1;
          bus.key <= bus.in_key[127:96];
          bus.text_in <= bus.in_text[127:96];
          state <= LOAD;
        end
        LOAD: begin
          beat <= nb;
          if (beat == 2'd3) begin
            bus.ld <= 1'b0;
            bus.key <= '0;
            bus.text_in <= '0;
            tcnt <= 8'd1;
            state <= WAIT;
          end else begin
            bus.key <= key_reg[{~nb, 5'd0} +: 32];
            bus.text_in <= text_reg[{~nb, 5'd0} +: 32];
          end
        end
        WAIT: if (bus.done) begin
          res <= {res[63:0], bus.text_out};
          beat <= 2'd1;
          state <= COLLECT;
        end else if (tcnt == TMAX) begin
          bus.timeout_err <= 1'b1;
          tcnt <= '0;
          state <= IDLE;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
        COLLECT: begin
          res <= {res[63:0], bus.text_out};
          beat <= nb;
          if (beat == 2'd3) begin
            bus.out_valid <= 1'b1;
            bus.out_data <= {res, bus.text_out};
            state <= HOLD;
          end
        end
        HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_word_sequencer.sv
// tb_aes_word_sequencer: random and directed blocks through the sequencer against a behavioural core model and scoreboard
module tb_aes_word_sequencer;
  localparam int TO = 8;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_mode = 0;
  int acc_cyc = 0;
  int d_cyc = 0;
  int to_cnt = 0;
  int to_exp = 0;
  int n_out = 0;
  int core_ph = 0;
  int core_nb = 0;
  int core_w = 0;
  int core_c = 0;
  int core_k = 0;
  bit core_sp = 1'b0;
  logic ov_prev = 1'b0;
  logic [31:0] kw[4];
  logic [31:0] tw[4];
  logic [127:0] core_res;
  logic [127:0] exp_q[$];
  int wk_q[$];
  bit sp_q[$];
  aes_word_sequencer_if bus();
  aes_word_sequencer #(.DONE_TIMEOUT(TO)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // the core's answer: the real FIPS-197 ciphertext for its vector, a fixed scramble otherwise
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
    return (k == FK && t == FP) ? FC : k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  task automatic chki(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event want event", name);
  endtask
  // core model: takes four ld beats, answers with done on WAIT cycle core_k (0 = never), then three more words
  initial begin
    bus.done = 1'b0;
    bus.text_out = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        core_ph = 0;
        core_nb = 0;
        bus.done = 1'b0;
        bus.text_out = '0;
      end else if (core_ph == 0) begin
        bus.done = 1'b0;
        bus.text_out = '0;
        if (bus.ld) begin
          if (core_nb == 0) begin
            if (wk_q.size() == 0) begin
              fail("core_params");
              core_k = 0;
              core_sp = 1'b0;
            end else begin
              core_k = wk_q.pop_front();
              core_sp = sp_q.pop_front();
            end
          end
          kw[core_nb] = bus.key;
          tw[core_nb] = bus.text_in;
          bus.done = core_sp && core_nb == 2;
          core_nb++;
          if (core_nb == 4) begin
            core_ph = 1;
            core_c = 0;
            core_res = core_fn({kw[0], kw[1], kw[2], kw[3]}, {tw[0], tw[1], tw[2], tw[3]});
          end
        end else if (core_nb != 0) begin
          fail("ld_gap");
        end
      end else if (core_ph == 1) begin
        core_c++;
        chk("ld_low", 128'({bus.ld, bus.key, bus.text_in}), '0);
        if (bus.in_ready) begin
          core_ph = 0;
          core_nb = 0;
        end else if (core_c == core_k) begin
          bus.done = 1'b1;
          bus.text_out = core_res[127:96];
          d_cyc = cyc;
          core_ph = 2;
          core_w = 1;
        end
      end else begin
        if (core_w == 4) begin
          core_ph = 0;
          core_nb = 0;
          bus.done = 1'b0;
          bus.text_out = '0;
        end else begin
          bus.done = core_sp;
          bus.text_out = core_res[127-32*core_w -: 32];
          core_w++;
        end
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    bus.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom % 2) : 1'b0;
  end
  // scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (bus.out_valid && !ov_prev) chki("latency", cyc - d_cyc, 4);
    ov_prev = bus.out_valid;
    if (bus.timeout_err) to_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) fail("unexpected_out");
      else chk("out_data", bus.out_data, exp_q.pop_front());
    end
  end
  task automatic issue(input logic [127:0] k, input logic [127:0] t, input int wk, input bit sp, input bit keep);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_key = k;
    bus.in_text = t;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 300);
    if (!bus.in_ready) begin
      fail("accept_wait");
    end else begin
      acc_cyc = cyc;
      wk_q.push_back(wk);
      sp_q.push_back(sp);
      if (wk > 0) exp_q.push_back(core_fn(k, t));
      else to_exp++;
    end
    @(posedge clk);
    #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || bus.busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("drain");
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bit ov;
    bus.in_valid = 1'b0;
    bus.in_key = '0;
    bus.in_text = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_port", 128'({bus.ld, bus.key, bus.text_in}), '0);
    chk("rst_out", 128'({bus.out_valid, bus.busy, bus.timeout_err}), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(FK, FP, 7, 1'b0, 1'b0);
    drain();
    chk("fips_key_words", {kw[0], kw[1], kw[2], kw[3]}, FK);
    chk("fips_text_words", {tw[0], tw[1], tw[2], tw[3]}, FP);
    chk("fips_out_kept", bus.out_data, FC);
    ready_mode = 2;
    issue(rnd128(), rnd128(), 5, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_ctrl", 128'({bus.out_valid, bus.in_ready}), 128'd2);
      chk("bp_data", bus.out_data, exp_q.size() > 0 ? exp_q[0] : '0);
    end
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release", 128'({bus.in_ready, bus.out_valid}), 128'd2);
    @(posedge clk);
    #1;
    issue(rnd128(), rnd128(), 0, 1'b0, 1'b0);
    n = 0;
    ov = 1'b0;
    while (!bus.timeout_err && n < 60) begin
      @(negedge clk);
      n++;
      ov |= bus.out_valid;
    end
    chki("to_cycle", cyc - acc_cyc, 13);
    chk("to_in_ready", 128'(bus.in_ready), 128'd1);
    chk("to_no_out", 128'(ov), '0);
    @(negedge clk);
    chk("to_pulse_end", 128'(bus.timeout_err), '0);
    @(posedge clk);
    #1;
    issue(rnd128(), rnd128(), TO, 1'b1, 1'b0);
    drain();
    chki("boundary_no_to", to_cnt, 1);
    issue(rnd128(), rnd128(), 3, 1'b0, 1'b0);
    n = 0;
    while (!(core_ph == 2 && core_w == 2) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_port", 128'({bus.ld, bus.key, bus.text_in, bus.out_valid, bus.busy, bus.timeout_err}), '0);
    chk("rst_mid_data", bus.out_data, '0);
    chk("rst_mid_in_ready", 128'(bus.in_ready), 128'd1);
    ov = 1'b0;
    repeat (6) begin
      @(negedge clk);
      ov |= bus.out_valid;
    end
    chk("rst_mid_no_out", 128'(ov), '0);
    @(posedge clk);
    #1;
    issue(rnd128(), rnd128(), 4, 1'b0, 1'b0);
    drain();
    n = n_out;
    issue(rnd128(), rnd128(), 2, 1'b0, 1'b1);
    issue(rnd128(), rnd128(), 6, 1'b1, 1'b1);
    issue(rnd128(), rnd128(), 1, 1'b0, 1'b0);
    drain();
    chki("b2b_count", n_out - n, 3);
    ready_mode = 1;
    for (int i = 0; i < 12; i++)
      issue(rnd128(), rnd128(), ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, TO)), 1'($urandom % 2), 1'b0);
    drain();
    repeat (12) @(negedge clk);
    chki("queue_empty", exp_q.size(), 0);
    chki("to_total", to_cnt, to_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
